data_mem_arbiter: RTL and testbench

Shares the single-port data memory between the RISCV_lite core and a second requester, the debug/DMA loader. It sits between both masters and the `data_mem` port. Each cycle it grants at most one access, using round-robin priority and an optional bounded lock for back-to-back bursts. It returns registered read data with a fixed one-cycle latency.

---
 rtl/data_mem_arb_pkg.sv | 14 +
 rtl/data_mem_arbiter_if.sv | 50 +++++
 rtl/arb_rr2.sv | 22 ++
 rtl/data_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// and the debug/DMA loader.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_C = 2'd1,
        LOCK_D = 2'd2
    } arb_state_e;

    localparam int REQ_C = 0;
    localparam int REQ_D = 1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundles both requester ports and the memory port of the data-memory arbiter.
// The slave side is the arbiter; the master side drives the requests and the memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              c_req;
    logic              c_we;
    logic              c_lock;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] data_address;
    logic [DATA_W-1:0] WriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] ReadData;

    modport slave (
        input  c_req, c_we, c_lock, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output data_address, WriteData, MemRead, MemWrite,
        input  ReadData
    );

    modport master (
        output c_req, c_we, c_lock, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  data_address, WriteData, MemRead, MemWrite,
        output ReadData
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a non-zero force mask overrides the pointer,
// otherwise a contended cycle goes to the requester the pointer favours.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic [1:0] force_mask,
    output logic [1:0] gnt
);

    // One-hot grant selection
    always_comb begin
        gnt = 2'b00;
        if (force_mask != 2'b00) begin
            gnt = force_mask & req;
        end else if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the core (C) and the debug/DMA
// loader (D): round-robin grants, bounded lock bursts, one-cycle read data.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic               clock,
    input  logic               reset,
    data_mem_arbiter_if.slave  bus
);

    localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_LOCK);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              ptr_q, ptr_d;
    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic [1:0]        req_s;
    logic [1:0]        force_mask_s;
    logic [1:0]        rr_gnt_s;
    logic [1:0]        gnt_s;
    logic              owner_hold_s;
    logic              any_gnt_s;
    logic              sel_d_s;
    logic              sel_we_s;
    logic              sel_lock_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    assign req_s = {bus.d_req, bus.c_req};

    // A lock owner that is still requesting is forced through; one that
    // dropped its request falls back to plain round-robin for this cycle.
    always_comb begin
        owner_hold_s = 1'b0;
        force_mask_s = 2'b00;
        case (state_q)
            LOCK_C: begin
                owner_hold_s = bus.c_req;
                force_mask_s = bus.c_req ? 2'b01 : 2'b00;
            end
            LOCK_D: begin
                owner_hold_s = bus.d_req;
                force_mask_s = bus.d_req ? 2'b10 : 2'b00;
            end
            default: begin
                owner_hold_s = 1'b0;
                force_mask_s = 2'b00;
            end
        endcase
    end

    arb_rr2 u_rr (
        .req        (req_s),
        .ptr        (ptr_q),
        .force_mask (force_mask_s),
        .gnt        (rr_gnt_s)
    );

    assign gnt_s      = reset ? 2'b00 : rr_gnt_s;
    assign any_gnt_s  = |gnt_s;
    assign sel_d_s    = gnt_s[REQ_D];
    assign sel_we_s   = sel_d_s ? bus.d_we   : bus.c_we;
    assign sel_lock_s = sel_d_s ? bus.d_lock : bus.c_lock;
    assign cnt_inc_s  = (lock_cnt_q >= MAX_CNT) ? MAX_CNT : lock_cnt_q + CNT_W'(1);

    // State, lock counter, pointer and read-data registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FREE;
            lock_cnt_q <= '0;
            ptr_q      <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            ptr_q      <= ptr_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next state: any grant points the round-robin at the other requester
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        ptr_d      = ptr_q;
        if (any_gnt_s) begin
            ptr_d = ~sel_d_s;
            if (owner_hold_s) begin
                if (!sel_lock_s || (cnt_inc_s == MAX_CNT)) begin
                    state_d    = FREE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_inc_s;
                end
            end else if (sel_lock_s && (MAX_LOCK > 1)) begin
                state_d    = sel_d_s ? LOCK_D : LOCK_C;
                lock_cnt_d = CNT_W'(1);
            end else begin
                state_d    = FREE;
                lock_cnt_d = '0;
            end
        end else begin
            state_d    = FREE;
            lock_cnt_d = '0;
        end
    end

    // Outputs: memory strobe mux, combinational grants, read-data capture
    always_comb begin
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        if (any_gnt_s) begin
            mem_addr_s  = sel_d_s ? bus.d_addr  : bus.c_addr;
            mem_wdata_s = sel_d_s ? bus.d_wdata : bus.c_wdata;
        end else begin
            mem_addr_s  = '0;
            mem_wdata_s = '0;
        end

        bus.c_gnt        = gnt_s[REQ_C];
        bus.d_gnt        = gnt_s[REQ_D];
        bus.data_address = mem_addr_s;
        bus.WriteData    = mem_wdata_s;
        bus.MemWrite     = any_gnt_s & sel_we_s;
        bus.MemRead      = any_gnt_s & ~sel_we_s;

        c_rvalid_d = gnt_s[REQ_C] & ~bus.c_we;
        d_rvalid_d = gnt_s[REQ_D] & ~bus.d_we;
        c_rdata_d  = c_rvalid_d ? bus.ReadData : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? bus.ReadData : d_rdata_q;

        bus.c_rvalid = c_rvalid_q;
        bus.d_rvalid = d_rvalid_q;
        bus.c_rdata  = c_rdata_q;
        bus.d_rdata  = d_rdata_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small word-addressed memory model.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic preload = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:63];

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
            mem[4]  <= 32'hDEADBEEF;
            mem[8]  <= 32'hA5A5A5A5;
            mem[13] <= 32'h34340000;
        end else if (bus.MemWrite) begin
            mem[bus.data_address[7:2]] <= bus.WriteData;
        end
    end

    assign bus.ReadData = mem[bus.data_address[7:2]];

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic clear_reqs();
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_lock = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        clear_reqs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        settle();
        n_checks++; if ({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.MemRead, bus.MemWrite} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.MemRead, bus.MemWrite}); else n_pass++;
        n_checks++; if ({bus.c_rdata, bus.d_rdata} !== 64'h0)
            $display("FAIL reset_rdata: got %h expected 0", {bus.c_rdata, bus.d_rdata}); else n_pass++;
        next_cycle();
        reset = 1'b0;
        preload = 1'b0;
    endtask

    task automatic test_core_read();
        next_cycle();
        clear_reqs();
        bus.c_req = 1'b1; bus.c_addr = 32'h10;
        settle();
        n_checks++; if ({bus.c_gnt, bus.d_gnt} !== 2'b10) $display("FAIL cread_gnt: got %b expected 10", {bus.c_gnt, bus.d_gnt}); else n_pass++;
        n_checks++; if ({bus.MemRead, bus.MemWrite} !== 2'b10) $display("FAIL cread_strobe: got %b expected 10", {bus.MemRead, bus.MemWrite}); else n_pass++;
        n_checks++; if (bus.data_address !== 32'h10) $display("FAIL cread_addr: got %h expected 10", bus.data_address); else n_pass++;
        next_cycle();
        clear_reqs();
        settle();
        n_checks++; if (bus.c_rvalid !== 1'b1) $display("FAIL cread_rvalid: got %b expected 1", bus.c_rvalid); else n_pass++;
        n_checks++; if (bus.c_rdata !== 32'hDEADBEEF) $display("FAIL cread_rdata: got %h expected deadbeef", bus.c_rdata); else n_pass++;
        n_checks++; if ({bus.d_gnt, bus.d_rvalid, bus.d_rdata} !== 34'h0) $display("FAIL cread_d_quiet: got %h expected 0", {bus.d_gnt, bus.d_rvalid, bus.d_rdata}); else n_pass++;
        next_cycle();
        settle();
        n_checks++; if (bus.c_rvalid !== 1'b0) $display("FAIL cread_rvalid_once: got %b expected 0", bus.c_rvalid); else n_pass++;
        n_checks++; if (bus.c_rdata !== 32'hDEADBEEF) $display("FAIL cread_rdata_hold: got %h expected deadbeef", bus.c_rdata); else n_pass++;
    endtask

    task automatic test_reset_write();
        next_cycle();
        reset = 1'b1;
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h20; bus.c_wdata = 32'h55;
        settle();
        n_checks++; if ({bus.MemWrite, bus.c_gnt} !== 2'b00) $display("FAIL rstwr_strobe: got %b expected 00", {bus.MemWrite, bus.c_gnt}); else n_pass++;
        next_cycle();
        reset = 1'b0;
        clear_reqs();
        settle();
        n_checks++; if (mem[8] !== 32'hA5A5A5A5) $display("FAIL rstwr_mem: got %h expected a5a5a5a5", mem[8]); else n_pass++;
        n_checks++; if ({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.MemRead, bus.MemWrite} !== 6'b0)
            $display("FAIL rstwr_ctrl: got %b expected 000000", {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.MemRead, bus.MemWrite}); else n_pass++;
        n_checks++; if (bus.c_rdata !== 32'h0) $display("FAIL rstwr_rdata: got %h expected 0", bus.c_rdata); else n_pass++;
        n_checks++; if ({bus.data_address, bus.WriteData} !== 64'h0) $display("FAIL rstwr_bus: got %h expected 0", {bus.data_address, bus.WriteData}); else n_pass++;
    endtask

    task automatic test_alternate();
        logic exp_c;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k == 0) begin
                bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h30; bus.c_wdata = 32'h111;
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h34;
            end
            settle();
            exp_c = ((k % 2) == 0);
            n_checks++; if ({bus.c_gnt, bus.d_gnt} !== {exp_c, ~exp_c}) $display("FAIL alt_gnt[%0d]: got %b expected %b", k, {bus.c_gnt, bus.d_gnt}, {exp_c, ~exp_c}); else n_pass++;
            n_checks++; if ({bus.MemWrite, bus.MemRead} !== {exp_c, ~exp_c}) $display("FAIL alt_strobe[%0d]: got %b expected %b", k, {bus.MemWrite, bus.MemRead}, {exp_c, ~exp_c}); else n_pass++;
            n_checks++; if (bus.data_address !== (exp_c ? 32'h30 : 32'h34)) $display("FAIL alt_addr[%0d]: got %h", k, bus.data_address); else n_pass++;
            n_checks++; if (bus.d_rvalid !== (k == 2)) $display("FAIL alt_drvalid[%0d]: got %b expected %b", k, bus.d_rvalid, (k == 2)); else n_pass++;
        end
        next_cycle();
        clear_reqs();
        settle();
        n_checks++; if (bus.d_rdata !== 32'h34340000) $display("FAIL alt_drdata: got %h expected 34340000", bus.d_rdata); else n_pass++;
        n_checks++; if (mem[12] !== 32'h111) $display("FAIL alt_mem: got %h expected 111", mem[12]); else n_pass++;
    endtask

    task automatic test_lock();
        logic exp_c;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            if (k == 0) begin
                bus.c_req = 1'b1; bus.c_lock = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10;
                bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h3C; bus.d_wdata = 32'h77;
            end
            settle();
            exp_c = (k != 4);
            n_checks++; if ({bus.c_gnt, bus.d_gnt} !== {exp_c, ~exp_c}) $display("FAIL lock_gnt[%0d]: got %b expected %b", k, {bus.c_gnt, bus.d_gnt}, {exp_c, ~exp_c}); else n_pass++;
            if (k > 0) begin
                n_checks++; if (bus.c_rvalid !== (k <= 4)) $display("FAIL lock_crvalid[%0d]: got %b expected %b", k, bus.c_rvalid, (k <= 4)); else n_pass++;
            end
            if (k == 4) begin
                n_checks++; if ({bus.MemWrite, bus.data_address} !== {1'b1, 32'h3C}) $display("FAIL lock_dwrite: got %h", {bus.MemWrite, bus.data_address}); else n_pass++;
            end
        end
        next_cycle();
        clear_reqs();
        settle();
        n_checks++; if (mem[15] !== 32'h77) $display("FAIL lock_mem: got %h expected 77", mem[15]); else n_pass++;
    endtask

    task automatic test_lock_drop();
        next_cycle();
        clear_reqs();
        bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 32'h10;
        settle();
        n_checks++; if ({bus.c_gnt, bus.d_gnt} !== 2'b01) $display("FAIL drop_dgnt: got %b expected 01", {bus.c_gnt, bus.d_gnt}); else n_pass++;
        next_cycle();
        n_checks++; if (dut.state_q !== LOCK_D) $display("FAIL drop_lockd: got %0d expected %0d", dut.state_q, LOCK_D); else n_pass++;
        clear_reqs();
        bus.c_req = 1'b1; bus.c_addr = 32'h34;
        settle();
        n_checks++; if ({bus.c_gnt, bus.d_gnt} !== 2'b10) $display("FAIL drop_cgnt: got %b expected 10", {bus.c_gnt, bus.d_gnt}); else n_pass++;
        n_checks++; if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'hDEADBEEF}) $display("FAIL drop_drdata: got %h", {bus.d_rvalid, bus.d_rdata}); else n_pass++;
        next_cycle();
        clear_reqs();
        n_checks++; if (dut.state_q !== FREE) $display("FAIL drop_free: got %0d expected %0d", dut.state_q, FREE); else n_pass++;
        settle();
        n_checks++; if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'h34340000}) $display("FAIL drop_crdata: got %h", {bus.c_rvalid, bus.c_rdata}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        next_cycle();
        clear_reqs();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h8; bus.d_wdata = 32'h1234;
        settle();
        n_checks++; if ({bus.d_gnt, bus.MemWrite, bus.WriteData} !== {2'b11, 32'h1234}) $display("FAIL b2b_write: got %h", {bus.d_gnt, bus.MemWrite, bus.WriteData}); else n_pass++;
        next_cycle();
        clear_reqs();
        bus.c_req = 1'b1; bus.c_addr = 32'h8;
        settle();
        n_checks++; if ({bus.c_gnt, bus.MemRead, bus.c_rvalid} !== 3'b110) $display("FAIL b2b_read: got %b expected 110", {bus.c_gnt, bus.MemRead, bus.c_rvalid}); else n_pass++;
        next_cycle();
        clear_reqs();
        settle();
        n_checks++; if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 32'h1234}) $display("FAIL b2b_rdata: got %h", {bus.c_rvalid, bus.c_rdata}); else n_pass++;
        n_checks++; if (bus.d_rvalid !== 1'b0) $display("FAIL b2b_drvalid: got %b expected 0", bus.d_rvalid); else n_pass++;
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_core_read();
        test_reset_write();
        test_alternate();
        test_lock();
        test_lock_drop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
